// File: rtl/conv_bias_add_pkg.sv
// conv_bias_add_pkg: lane geometry and FSM encoding shared by the bias-add block.
// CHANNEL_OUT_NUM mirrors Channel_Out_Num from Para.v.
package conv_bias_add_pkg;
    localparam int CHANNEL_OUT_NUM = 4;
    localparam int LANE_W          = 32;
    localparam int VEC_W           = CHANNEL_OUT_NUM * LANE_W;
    typedef enum logic [1:0] {IDLE, FETCH, RUN, FLUSH} state_t;
endpackage

// File: rtl/conv_bias_add_if.sv
// conv_bias_add_if: valid/ready vector stream of CHANNEL_OUT_NUM packed 32-bit lanes.
interface conv_bias_add_if
    import conv_bias_add_pkg::*;
#(
    parameter int W = VEC_W
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/conv_bias_add_lane.sv
// conv_bias_add_lane: combinational 32-bit signed accumulator + bias for one lane.
// With BIAS_SAT_EN defined the sum clamps to the signed 32-bit range, otherwise it wraps.
module conv_bias_add_lane
    import conv_bias_add_pkg::*;
(
    input  logic [LANE_W-1:0] acc_i,
    input  logic [LANE_W-1:0] bias_i,
    output logic [LANE_W-1:0] sum_o
);
    logic [LANE_W-1:0] raw;
    assign raw = acc_i + bias_i;
`ifdef BIAS_SAT_EN
    // Overflow only when both operands share a sign the sum has lost.
    logic ovf;
    assign ovf   = (acc_i[LANE_W-1] == bias_i[LANE_W-1]) && (raw[LANE_W-1] != acc_i[LANE_W-1]);
    assign sum_o = ovf ? {acc_i[LANE_W-1], {(LANE_W-1){~acc_i[LANE_W-1]}}} : raw;
`else
    assign sum_o = raw;
`endif
endmodule

// File: rtl/conv_bias_add.sv
// conv_bias_add: fetches one bias vector per output-channel group and adds it lane-wise to the
// accumulator stream. Define BIAS_SAT_EN for saturating lanes; the default build wraps modulo 2^32.
module conv_bias_add
    import conv_bias_add_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int PIX_BITS    = 16,
    parameter int BIAS_RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [ADDR_BITS-2:0] cfg_group_num_i,
    input  logic [PIX_BITS-1:0]  cfg_pixel_num_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ADDR_BITS-1:0] bias_rd_addr_o,
    input  logic [VEC_W-1:0]     bias_rd_data_i,
    conv_bias_add_if.slave       s_if,
    conv_bias_add_if.master      m_if
);
    localparam int            GW       = ADDR_BITS - 1;
    localparam int            LW       = $clog2(BIAS_RD_LAT + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(BIAS_RD_LAT);

    state_t              state_q;
    logic [GW-1:0]       grp_num_q, grp_idx_q;
    logic [PIX_BITS-1:0] pix_num_q, pix_cnt_q;
    logic [LW-1:0]       lat_q;
    logic [VEC_W-1:0]    bias_q, m_data_q, sum_d;
    logic                m_valid_q, busy_q, done_q, in_hs, pix_last, grp_last;

    for (genvar i = 0; i < CHANNEL_OUT_NUM; i++) begin : g_lane
        conv_bias_add_lane u_lane (
            .acc_i  (s_if.data[i*LANE_W +: LANE_W]),
            .bias_i (bias_q[i*LANE_W +: LANE_W]),
            .sum_o  (sum_d[i*LANE_W +: LANE_W])
        );
    end

    assign s_if.ready     = (state_q == RUN) && (!m_valid_q || m_if.ready);
    assign in_hs          = s_if.valid && s_if.ready;
    assign pix_last       = pix_cnt_q == pix_num_q - PIX_BITS'(1);
    assign grp_last       = grp_idx_q == grp_num_q - GW'(1);
    assign m_if.data      = m_data_q;
    assign m_if.valid     = m_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign bias_rd_addr_o = {1'b0, grp_idx_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grp_num_q <= '0;
            grp_idx_q <= '0;
            pix_num_q <= '0;
            pix_cnt_q <= '0;
            lat_q     <= '0;
            bias_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (m_if.ready) m_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    grp_num_q <= cfg_group_num_i;
                    pix_num_q <= cfg_pixel_num_i;
                    pix_cnt_q <= '0;
                    lat_q     <= '0;
                    busy_q    <= 1'b1;
                    // Empty layers skip the RAM entirely, leaving the address untouched.
                    if (cfg_group_num_i == '0 || cfg_pixel_num_i == '0) begin
                        state_q <= FLUSH;
                    end else begin
                        grp_idx_q <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: if (lat_q == LAT_LAST) begin
                    bias_q  <= bias_rd_data_i;
                    state_q <= RUN;
                end else begin
                    lat_q <= lat_q + LW'(1);
                end
                RUN: if (in_hs) begin
                    m_data_q  <= sum_d;
                    m_valid_q <= 1'b1;
                    pix_cnt_q <= pix_cnt_q + PIX_BITS'(1);
                    if (pix_last) begin
                        pix_cnt_q <= '0;
                        if (grp_last) begin
                            state_q <= FLUSH;
                        end else begin
                            grp_idx_q <= grp_idx_q + GW'(1);
                            lat_q     <= '0;
                            state_q   <= FETCH;
                        end
                    end
                end
                FLUSH: if (!m_valid_q || m_if.ready) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
